wf_gather_cnt_bank: RTL and testbench
=====================================

Name: wf_gather_cnt_bank

Overview:
Parametrised per-warp gather counter bank and the next generation of the fixed 16x3 gather-count RAM. It holds one saturating counter and one target value per warp. Counters take up to NUM_INC same-cycle increments from independent writeback lanes. The bank raises a per-warp done flag when a counter reaches its armed target, and serves a 1-cycle registered read with same-edge forwarding. It sits between the LSU/writeback gather path and the warp scheduler, which consumes done_mask and acknowledges it.

Parameters:
NUM_WARP, 16, number of warps (counters); power of two, >=2
CNT_W, 3, counter and target width in bits
NUM_INC, 2, number of independent increment ports, 1..4
ADDR_W, $clog2(NUM_WARP), warp id width (derived, not overridable)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
io_inc_valid  in  NUM_INC  per-lane increment request
io_inc_wid  in  NUM_INC*ADDR_W  per-lane target warp id, lane k at bits [k*ADDR_W +: ADDR_W]
io_init_valid  in  1  arm a warp: load target, restart its count
io_init_wid  in  ADDR_W  warp to arm
io_init_target  in  CNT_W  expected gather count; 0 is illegal and is ignored
io_ack_valid  in  1  scheduler consumed done for a warp
io_ack_wid  in  ADDR_W  warp being acknowledged
io_rd_en  in  1  read request
io_rd_wid  in  ADDR_W  warp to read
io_rd_data  out  CNT_W  counter value, one cycle after io_rd_en
io_done_mask  out  NUM_WARP  bit w = warp w armed and cnt[w] >= tgt[w]
io_ovf  out  1  sticky saturation error

Behaviour:
- Reset is asynchronous: cnt, tgt, armed, rd_data register and ovf all clear to 0, so io_done_mask = 0. Storage is never left uninitialised or randomised.
- Per-warp delta: delta[w] = number of lanes k with inc_valid[k] && inc_wid[k]==w, range 0..NUM_INC. Duplicate ids across lanes all count.
- Next count: base = (init_valid && init_wid==w) ? 0 : cnt[w]. sum = base + delta[w], computed at CNT_W+3 bits.
- Saturation: if sum > 2^CNT_W-1, cnt[w] <= 2^CNT_W-1 and ovf <= 1. ovf is cleared only by reset.
- Init: when init_valid and init_target != 0, then tgt[w] <= init_target and armed[w] <= 1. Same-cycle increments to w count on top of 0. When init_target == 0, the whole init is a no-op: cnt is not cleared.
- Ack: armed[w] <= 0. If init and ack name the same warp in the same cycle, init wins (armed=1). Ack does not modify cnt.
- done_mask[w] = armed[w] && (cnt[w] >= tgt[w]). It is driven purely from registers, so it rises one cycle after the completing increment edge.
- Read timing: io_rd_en is sampled at edge T. io_rd_data after T equals cnt[rd_wid] as written at edge T, i.e. forwarding includes the same-edge init, increments and saturation.
- When io_rd_en is low, io_rd_data holds its last value.
- All updates are single-cycle; the bank never stalls and there are no ready signals.
- Wrap-around does not exist: counters saturate and never wrap.
- A reset asserted mid-operation discards everything immediately. Inputs are ignored while reset is high.

Decomposition:
- Shared package wf_gather_pkg:
  - WG_ADDR_W(n) function
  - CNT_MAX(w) constant function
  - increment-lane struct typedef {valid, wid}
- Sub-module wf_gather_delta: NUM_INC lanes in, per-warp delta vector out (NUM_WARP x $clog2(NUM_INC+1)). It is purely combinational and reused by the scheduler-side credit logic.
- Top level holds the register arrays, init/ack/saturation logic and the read register.

Test Plan:
- Reset values: reset pulse with inputs toggling -> rd_data=0, done_mask=0, ovf=0. A read of every warp returns 0.
- Arm and complete: init w5 target 3, then inc lane0 w5 for three cycles -> done_mask[5] rises the cycle after the 3rd edge. Reading w5 returns 3. Ack w5 -> done_mask[5] falls next cycle while cnt stays 3.
- Dual-lane same warp: NUM_INC=2, both lanes inc w2 in one cycle with rd_en w2 in the same cycle -> rd_data=2 next cycle (forwarding).
- Saturation: CNT_W=3, 7 single increments to w9, then one dual increment -> cnt=7, ovf=1 and stays 1. Other warps are unaffected.
- Init collision: cnt[4]=6, then in one cycle init w4 target 2 plus inc w4 on both lanes plus ack w4 -> cnt=2, armed=1, done_mask[4]=1 next cycle.
- Illegal init and mid-op reset: init w1 target 0 leaves cnt/tgt/armed unchanged. Asserting reset while increments are streaming clears everything asynchronously, before the next edge.

Source files
------------

// File: rtl/wf_gather_pkg.sv
// -----------------------------------------------------------------------------
// wf_gather_pkg
// Shared definitions for the per-warp gather counter bank and its helpers.
//   WG_ADDR_W(n)   : warp-id width needed to address n warps (min 1)
//   CNT_MAX(w)     : largest value of a w-bit saturating counter
//   wg_inc_lane_t  : one writeback increment lane {valid, wid}
// The lane struct carries a fixed-width warp id, wide enough for up to 256
// warps; users zero-extend their ADDR_W-bit ids into it.
// -----------------------------------------------------------------------------
package wf_gather_pkg;

    localparam int WG_WID_MAX = 8;

    function automatic int WG_ADDR_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int CNT_MAX(input int w);
        return (1 << w) - 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [WG_WID_MAX-1:0] wid;
    } wg_inc_lane_t;

endpackage

// File: rtl/wf_gather_delta.sv
// -----------------------------------------------------------------------------
// wf_gather_delta
// Purely combinational: counts, for every warp, how many increment lanes
// target it this cycle. Duplicate ids across lanes all count.
// Ports:
//   i_lanes  in   NUM_INC increment lanes {valid, wid}
//   o_delta  out  per-warp lane count, NUM_WARP x D_W bits
// -----------------------------------------------------------------------------
module wf_gather_delta
    import wf_gather_pkg::*;
#(
    parameter int NUM_WARP = 16,
    parameter int NUM_INC  = 2,
    localparam int D_W     = $clog2(NUM_INC + 1)
) (
    input  wg_inc_lane_t [NUM_INC-1:0]            i_lanes,
    output logic         [NUM_WARP-1:0][D_W-1:0]  o_delta
);

    always_comb begin
        o_delta = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            for (int k = 0; k < NUM_INC; k++) begin
                if (i_lanes[k].valid && (i_lanes[k].wid == WG_WID_MAX'(w))) begin
                    o_delta[w] = o_delta[w] + D_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/wf_gather_cnt_bank.sv
// -----------------------------------------------------------------------------
// wf_gather_cnt_bank
// Per-warp saturating gather counters with armed targets. A warp is armed by
// init (non-zero target), counts increments from NUM_INC writeback lanes and
// flags done once its count reaches the target; the scheduler acks to disarm.
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   io_inc_valid / io_inc_wid          per-lane increment requests
//   io_init_valid/_wid/_target         arm a warp and restart its count
//   io_ack_valid / io_ack_wid          disarm a warp (init wins on collision)
//   io_rd_en / io_rd_wid / io_rd_data  registered read, forwards same-edge writes
//   io_done_mask                       armed && cnt >= tgt, per warp
//   io_ovf                             sticky saturation flag
// -----------------------------------------------------------------------------
module wf_gather_cnt_bank
    import wf_gather_pkg::*;
#(
    parameter int NUM_WARP = 16,
    parameter int CNT_W    = 3,
    parameter int NUM_INC  = 2,
    localparam int ADDR_W  = WG_ADDR_W(NUM_WARP)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_INC-1:0]          io_inc_valid,
    input  logic [NUM_INC*ADDR_W-1:0]   io_inc_wid,
    input  logic                        io_init_valid,
    input  logic [ADDR_W-1:0]           io_init_wid,
    input  logic [CNT_W-1:0]            io_init_target,
    input  logic                        io_ack_valid,
    input  logic [ADDR_W-1:0]           io_ack_wid,
    input  logic                        io_rd_en,
    input  logic [ADDR_W-1:0]           io_rd_wid,
    output logic [CNT_W-1:0]            io_rd_data,
    output logic [NUM_WARP-1:0]         io_done_mask,
    output logic                        io_ovf
);

    localparam int D_W   = $clog2(NUM_INC + 1);
    // Three spare bits cover up to 4 lanes landing on a full counter.
    localparam int SUM_W = CNT_W + 3;

    logic [NUM_WARP-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_WARP-1:0][CNT_W-1:0] r_tgt;
    logic [NUM_WARP-1:0]            r_armed;
    logic [CNT_W-1:0]               r_rd_data;
    logic                           r_ovf;

    wg_inc_lane_t [NUM_INC-1:0]     w_lanes;
    logic [NUM_WARP-1:0][D_W-1:0]   w_delta;
    logic [NUM_WARP-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NUM_WARP-1:0]            w_arm;
    logic [NUM_WARP-1:0]            w_ack;
    logic [NUM_WARP-1:0]            w_sat;

    for (genvar k = 0; k < NUM_INC; k++) begin : g_lane
        assign w_lanes[k].valid = io_inc_valid[k];
        assign w_lanes[k].wid   = WG_WID_MAX'(io_inc_wid[k*ADDR_W +: ADDR_W]);
    end

    wf_gather_delta #(
        .NUM_WARP (NUM_WARP),
        .NUM_INC  (NUM_INC)
    ) u_delta (
        .i_lanes  (w_lanes),
        .o_delta  (w_delta)
    );

    for (genvar g = 0; g < NUM_WARP; g++) begin : g_warp
        logic [SUM_W-1:0] w_sum;

        // A zero target makes the whole init a no-op, including the restart.
        assign w_arm[g] = io_init_valid && (io_init_target != '0)
                          && (io_init_wid == ADDR_W'(g));
        assign w_ack[g] = io_ack_valid && (io_ack_wid == ADDR_W'(g));

        assign w_sum = SUM_W'(w_arm[g] ? {CNT_W{1'b0}} : r_cnt[g])
                     + SUM_W'(w_delta[g]);
        assign w_sat[g]     = w_sum > SUM_W'(CNT_MAX(CNT_W));
        assign w_cnt_nxt[g] = w_sat[g] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

        assign io_done_mask[g] = r_armed[g] && (r_cnt[g] >= r_tgt[g]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_armed   <= '0;
            r_rd_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            for (int w = 0; w < NUM_WARP; w++) begin
                if (w_arm[w]) begin
                    r_armed[w] <= 1'b1;
                    r_tgt[w]   <= io_init_target;
                end else if (w_ack[w]) begin
                    r_armed[w] <= 1'b0;
                end
            end
            if (|w_sat) begin
                r_ovf <= 1'b1;
            end
            // Read the post-update value so same-edge writes are forwarded.
            if (io_rd_en) begin
                r_rd_data <= w_cnt_nxt[io_rd_wid];
            end
        end
    end

    assign io_rd_data = r_rd_data;
    assign io_ovf     = r_ovf;

endmodule

// File: tb/tb_wf_gather_cnt_bank.sv
module tb_wf_gather_cnt_bank;

    localparam int NW   = 16;
    localparam int CW   = 3;
    localparam int NI   = 2;
    localparam int AW   = 4;
    localparam int CMAX = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic [NI-1:0]    inc_valid;
    logic [NI*AW-1:0] inc_wid;
    logic             init_valid;
    logic [AW-1:0]    init_wid;
    logic [CW-1:0]    init_target;
    logic             ack_valid;
    logic [AW-1:0]    ack_wid;
    logic             rd_en;
    logic [AW-1:0]    rd_wid;
    logic [CW-1:0]    rd_data;
    logic [NW-1:0]    done_mask;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt [NW];
    int m_tgt [NW];
    bit m_armed [NW];
    int m_rd;
    bit m_ovf;

    wf_gather_cnt_bank #(.NUM_WARP(NW), .CNT_W(CW), .NUM_INC(NI)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_inc_valid   (inc_valid),
        .io_inc_wid     (inc_wid),
        .io_init_valid  (init_valid),
        .io_init_wid    (init_wid),
        .io_init_target (init_target),
        .io_ack_valid   (ack_valid),
        .io_ack_wid     (ack_wid),
        .io_rd_en       (rd_en),
        .io_rd_wid      (rd_wid),
        .io_rd_data     (rd_data),
        .io_done_mask   (done_mask),
        .io_ovf         (ovf)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_cnt[w] = 0; m_tgt[w] = 0; m_armed[w] = 0;
        end
        m_rd = 0; m_ovf = 0;
    endtask

    // One clock edge of the bank, written from the behavioural rules.
    task automatic model_step();
        int nc [NW];
        for (int w = 0; w < NW; w++) begin
            int hits = 0;
            bit arm;
            for (int k = 0; k < NI; k++)
                if (inc_valid[k] && int'(inc_wid[k*AW +: AW]) == w) hits++;
            arm = init_valid && init_target != 0 && int'(init_wid) == w;
            nc[w] = (arm ? 0 : m_cnt[w]) + hits;
            if (nc[w] > CMAX) begin nc[w] = CMAX; m_ovf = 1; end
            if (ack_valid && int'(ack_wid) == w) m_armed[w] = 0;
            if (arm) begin m_armed[w] = 1; m_tgt[w] = int'(init_target); end
        end
        for (int w = 0; w < NW; w++) m_cnt[w] = nc[w];
        if (rd_en) m_rd = m_cnt[rd_wid];
    endtask

    function automatic logic [NW-1:0] exp_done();
        logic [NW-1:0] d;
        for (int w = 0; w < NW; w++) d[w] = m_armed[w] && (m_cnt[w] >= m_tgt[w]);
        return d;
    endfunction

    task automatic idle();
        inc_valid = '0; inc_wid = '0;
        init_valid = 0; init_wid = '0; init_target = '0;
        ack_valid = 0; ack_wid = '0;
        rd_en = 0; rd_wid = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        #1;
    endtask

    task automatic read_warp(input int w);
        idle(); rd_en = 1; rd_wid = AW'(w);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            inc_valid = NI'($urandom); inc_wid = (NI*AW)'($urandom);
            init_valid = 1'($urandom); init_wid = AW'($urandom);
            init_target = CW'($urandom); rd_en = 1'($urandom);
            tick();
        end
        model_reset();
        n_tests++;
        if (rd_data !== 3'd0 || done_mask !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%0d done=%h ovf=%0b, want 0/0/0", rd_data, done_mask, ovf);
        end
        idle();
        reset = 0;
        for (int w = 0; w < NW; w++) begin
            read_warp(w);
            n_tests++;
            if (rd_data !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_read_w%0d: got %0d want 0", w, rd_data);
            end
        end
    endtask

    task automatic test_arm_complete();
        idle(); init_valid = 1; init_wid = 5; init_target = 3;
        tick();
        for (int i = 1; i <= 3; i++) begin
            idle(); inc_valid = 2'b01; inc_wid = {4'd0, 4'd5};
            tick();
            n_tests++;
            if (done_mask[5] !== (i == 3) || done_mask !== exp_done()) begin
                n_fail++;
                $display("FAIL arm_done_inc%0d: done=%h want %h", i, done_mask, exp_done());
            end
        end
        read_warp(5);
        n_tests++;
        if (rd_data !== 3'd3) begin
            n_fail++; $display("FAIL arm_read_w5: got %0d want 3", rd_data);
        end
        idle(); ack_valid = 1; ack_wid = 5;
        tick();
        n_tests++;
        if (done_mask[5] !== 1'b0) begin
            n_fail++; $display("FAIL ack_done_w5: got %0b want 0", done_mask[5]);
        end
        read_warp(5);
        n_tests++;
        if (rd_data !== 3'd3) begin
            n_fail++; $display("FAIL ack_keeps_cnt_w5: got %0d want 3", rd_data);
        end
    endtask

    task automatic test_dual_lane();
        idle(); inc_valid = 2'b11; inc_wid = {4'd2, 4'd2}; rd_en = 1; rd_wid = 2;
        tick();
        n_tests++;
        if (rd_data !== 3'd2 || m_rd != 2) begin
            n_fail++; $display("FAIL dual_forward_w2: got %0d want 2", rd_data);
        end
        idle(); tick();
        n_tests++;
        if (rd_data !== 3'd2) begin
            n_fail++; $display("FAIL rd_hold: got %0d want 2", rd_data);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) begin
            idle(); inc_valid = 2'b10; inc_wid = {4'd9, 4'd0};
            tick();
        end
        read_warp(9);
        n_tests++;
        if (rd_data !== 3'd7 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL sat_fill_w9: rd=%0d ovf=%0b want 7/0", rd_data, ovf);
        end
        idle(); inc_valid = 2'b11; inc_wid = {4'd9, 4'd9}; rd_en = 1; rd_wid = 9;
        tick();
        n_tests++;
        if (rd_data !== 3'd7 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL sat_over_w9: rd=%0d ovf=%0b want 7/1", rd_data, ovf);
        end
        idle(); tick(); tick();
        n_tests++;
        if (ovf !== 1'b1 || done_mask !== exp_done()) begin
            n_fail++; $display("FAIL sat_sticky: ovf=%0b done=%h want 1/%h", ovf, done_mask, exp_done());
        end
        read_warp(2);
        n_tests++;
        if (rd_data !== 3'd2) begin
            n_fail++; $display("FAIL sat_other_w2: got %0d want 2", rd_data);
        end
    endtask

    task automatic test_init_collision();
        for (int i = 0; i < 3; i++) begin
            idle(); inc_valid = 2'b11; inc_wid = {4'd4, 4'd4};
            tick();
        end
        read_warp(4);
        n_tests++;
        if (rd_data !== 3'd6) begin
            n_fail++; $display("FAIL coll_pre_w4: got %0d want 6", rd_data);
        end
        idle();
        init_valid = 1; init_wid = 4; init_target = 2;
        inc_valid = 2'b11; inc_wid = {4'd4, 4'd4};
        ack_valid = 1; ack_wid = 4;
        rd_en = 1; rd_wid = 4;
        tick();
        n_tests++;
        if (rd_data !== 3'd2 || done_mask[4] !== 1'b1 || done_mask !== exp_done()) begin
            n_fail++;
            $display("FAIL coll_w4: rd=%0d done=%h want 2/%h", rd_data, done_mask, exp_done());
        end
    endtask

    task automatic test_illegal_init_midreset();
        idle(); init_valid = 1; init_wid = 1; init_target = 2;
        tick();
        idle(); inc_valid = 2'b01; inc_wid = {4'd0, 4'd1};
        tick();
        idle(); init_valid = 1; init_wid = 1; init_target = 0; rd_en = 1; rd_wid = 1;
        tick();
        n_tests++;
        if (rd_data !== 3'd1 || done_mask[1] !== 1'b0) begin
            n_fail++; $display("FAIL init0_noop_w1: rd=%0d done=%0b want 1/0", rd_data, done_mask[1]);
        end
        idle(); inc_valid = 2'b01; inc_wid = {4'd0, 4'd1};
        tick();
        n_tests++;
        if (done_mask[1] !== 1'b1) begin
            n_fail++; $display("FAIL init0_keeps_tgt_w1: done=%0b want 1", done_mask[1]);
        end
        idle(); init_valid = 1; init_wid = 3; init_target = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(); inc_valid = 2'b11; inc_wid = {4'd7, 4'd3}; rd_en = 1; rd_wid = 3;
            tick();
        end
        n_tests++;
        if (rd_data !== 3'd4 || done_mask !== exp_done() || ovf !== 1'b1) begin
            n_fail++; $display("FAIL stream_pre_reset: rd=%0d done=%h ovf=%0b", rd_data, done_mask, ovf);
        end
        #2 reset = 1;
        #1;
        n_tests++;
        if (rd_data !== 3'd0 || done_mask !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: rd=%0d done=%h ovf=%0b want 0/0/0", rd_data, done_mask, ovf);
        end
        model_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 0;
        read_warp(3);
        n_tests++;
        if (rd_data !== 3'd0 || done_mask !== '0) begin
            n_fail++; $display("FAIL post_reset_w3: rd=%0d done=%h want 0/0", rd_data, done_mask);
        end
    endtask

    task automatic test_random();
        idle(); reset = 1; tick(); model_reset(); reset = 0;
        for (int i = 0; i < 400; i++) begin
            inc_valid   = NI'($urandom);
            inc_wid     = (NI*AW)'($urandom);
            init_valid  = ($urandom_range(0, 2) == 0);
            init_wid    = AW'($urandom);
            init_target = CW'($urandom);
            ack_valid   = ($urandom_range(0, 3) == 0);
            ack_wid     = AW'($urandom);
            rd_en       = 1'($urandom);
            rd_wid      = AW'($urandom);
            tick();
            n_tests++;
            if (rd_data !== CW'(m_rd) || done_mask !== exp_done() || ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL random_c%0d: rd=%0d done=%h ovf=%0b want %0d/%h/%0b",
                         i, rd_data, done_mask, ovf, m_rd, exp_done(), m_ovf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        test_reset();
        test_arm_complete();
        test_dual_lane();
        test_saturation();
        test_init_collision();
        test_illegal_init_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
